// File: rtl/sample_packetizer.sv
// Frames multi-channel ADC samples into sync/header/data/checksum byte packets
// on an AXI-Stream byte output; samples arriving mid-packet are dropped and counted.
module sample_packetizer #(
   parameter int unsigned NUM_CH    = 2,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   sample_valid,
   input  logic [16*NUM_CH-1:0]   sample_data,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   busy,
   output logic [15:0]            drop_count
);
   localparam int unsigned NB = 2 * NUM_CH;
   localparam int unsigned DW = 16 * NUM_CH;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      HDR  = 3'd2,
      DATA = 3'd3,
      CSUM = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] sh_q, sh_d, ordered;
   logic [7:0]    hdr_q, hdr_d;
   logic [7:0]    csum_q, csum_d;
   logic [7:0]    tdata_q, tdata_d;
   logic          tvalid_q, tvalid_d;
   logic          tlast_q, tlast_d;
   logic          pend_q, pend_d;
   logic [6:0]    seq_q, seq_d;
   logic [3:0]    idx_q, idx_d;
   logic [15:0]   drop_q, drop_d;
   logic          hs, accept;

   // ch0 lands in the top bits so the packet shifts out MSB first
   always_comb begin
      ordered = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ordered[DW-1-16*c -: 16] = sample_data[16*c +: 16];
      end
   end

   assign hs     = tvalid_q && m_axis_tready;
   assign accept = sample_valid &&
                   ((state_q == IDLE) || ((state_q == CSUM) && hs));

   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      hdr_d    = hdr_q;
      csum_d   = csum_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      pend_d   = pend_q;
      seq_d    = seq_q;
      idx_d    = idx_q;
      drop_d   = drop_q;
      if (hs) begin
         unique case (state_q)
            SYNC: begin
               state_d = HDR;
               tdata_d = hdr_q;
            end
            HDR: begin
               state_d = DATA;
               csum_d  = csum_q + tdata_q;
               tdata_d = sh_q[DW-1 -: 8];
               sh_d    = sh_q << 8;
               idx_d   = '0;
            end
            DATA: begin
               csum_d = csum_q + tdata_q;
               if (idx_q == 4'(NB - 1)) begin
                  state_d = CSUM;
                  tdata_d = csum_q + tdata_q;
                  tlast_d = 1'b1;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  tdata_d = sh_q[DW-1 -: 8];
                  sh_d    = sh_q << 8;
               end
            end
            CSUM: begin
               state_d  = IDLE;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               tdata_d  = '0;
            end
            default: ;
         endcase
      end
      // accept overrides the CSUM->IDLE move so back-to-back has no bubble
      if (accept) begin
         state_d  = SYNC;
         sh_d     = ordered;
         hdr_d    = {pend_q, seq_q};
         pend_d   = 1'b0;
         seq_d    = seq_q + 7'd1;
         csum_d   = '0;
         tdata_d  = SYNC_BYTE;
         tvalid_d = 1'b1;
         tlast_d  = 1'b0;
         idx_d    = '0;
      end else if (sample_valid) begin
         pend_d = 1'b1;
         if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= IDLE;
         sh_q     <= '0;
         hdr_q    <= '0;
         csum_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         pend_q   <= 1'b0;
         seq_q    <= '0;
         idx_q    <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         hdr_q    <= hdr_d;
         csum_q   <= csum_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         pend_q   <= pend_d;
         seq_q    <= seq_d;
         idx_q    <= idx_d;
         drop_q   <= drop_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = (state_q != IDLE);
   assign drop_count    = drop_q;
endmodule

// File: tb/tb_sample_packetizer.sv
// Directed-vector bench for sample_packetizer (NUM_CH=2).
// Inputs change and outputs are observed on the falling edge.
module tb_sample_packetizer;
   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        sample_valid;
   logic [31:0] sample_data;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        busy;
   logic [15:0] drop_count;

   int checks = 0;
   int fails  = 0;

   logic [7:0] cap_b [0:31];
   int         cap_n, cap_tlcnt, cap_tlpos, cap_first, cap_stall;
   bit         cap_to;

   sample_packetizer #(.NUM_CH(2), .SYNC_BYTE(8'hA5)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .sample_valid  (sample_valid),
      .sample_data   (sample_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .drop_count    (drop_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic apply_reset();
      @(negedge sys_clk);
      sample_valid = 1'b0;
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   task automatic strobe(input logic [31:0] d);
      @(negedge sys_clk);
      sample_valid = 1'b1;
      sample_data  = d;
   endtask

   // Records handshaken bytes until tlast, with a cycle bound.
   task automatic capture(input bit tog, input int extra_at,
                          input logic [31:0] extra_d,
                          input bit strobe_last,
                          input logic [31:0] last_d);
      logic       pv, pr, pl;
      logic [7:0] pd;
      bit         done;
      cap_n = 0; cap_tlcnt = 0; cap_tlpos = -1;
      cap_first = -1; cap_stall = 0; cap_to = 1'b1;
      done = 1'b0; pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge sys_clk);
         sample_valid = (k == extra_at);
         if (k == extra_at) sample_data = extra_d;
         m_axis_tready = tog ? (k % 2 == 0) : 1'b1;
         if (pv && !pr && (m_axis_tvalid !== 1'b1 ||
             m_axis_tdata !== pd || m_axis_tlast !== pl))
            cap_stall++;
         if (m_axis_tvalid === 1'b1 && cap_first < 0) cap_first = k;
         if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
            if (cap_n < 32) cap_b[cap_n] = m_axis_tdata;
            if (m_axis_tlast === 1'b1) begin
               cap_tlcnt++;
               cap_tlpos = cap_n;
               done = 1'b1;
               cap_to = 1'b0;
               if (strobe_last) begin
                  sample_valid = 1'b1;
                  sample_data  = last_d;
               end
            end
            cap_n++;
         end
         pv = m_axis_tvalid; pr = m_axis_tready;
         pd = m_axis_tdata;  pl = m_axis_tlast;
      end
   endtask

   task automatic test_reset();
      @(negedge sys_clk);
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
         fails++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid);
      end
      checks++;
      if (m_axis_tlast !== 1'b0) begin
         fails++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast);
      end
      checks++;
      if (m_axis_tdata !== 8'h00) begin
         fails++; $display("FAIL rst_tdata got %h want 00", m_axis_tdata);
      end
      checks++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL rst_busy got %b want 0", busy);
      end
      checks++;
      if (drop_count !== 16'h0000) begin
         fails++; $display("FAIL rst_drop got %h want 0000", drop_count);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp [0:6] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
      strobe(32'hABCD_1234);
      capture(1'b0, -1, '0, 1'b0, '0);
      checks++;
      if (cap_to || cap_n != 7 || cap_tlcnt != 1 || cap_tlpos != 6) begin
         fails++;
         $display("FAIL basic_frame got n=%0d tlast=%0d@%0d to=%0b want n=7 tlast=1@6",
                  cap_n, cap_tlcnt, cap_tlpos, cap_to);
      end
      checks++;
      if (cap_first != 0) begin
         fails++; $display("FAIL basic_latency got %0d want 0", cap_first);
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_b[i] !== exp[i]) begin
            fails++; $display("FAIL basic_b%0d got %h want %h", i, cap_b[i], exp[i]);
         end
      end
      @(negedge sys_clk);
      checks++;
      if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
         fails++; $display("FAIL basic_idle got busy=%b tvalid=%b want 0 0", busy, m_axis_tvalid);
      end
   endtask

   task automatic test_stall();
      logic [7:0] exp [0:6] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
      strobe(32'hABCD_1234);
      capture(1'b1, -1, '0, 1'b0, '0);
      checks++;
      if (cap_to || cap_n != 7 || cap_tlpos != 6) begin
         fails++; $display("FAIL stall_frame got n=%0d tlast@%0d want n=7 tlast@6", cap_n, cap_tlpos);
      end
      checks++;
      if (cap_stall != 0) begin
         fails++; $display("FAIL stall_hold got %0d unstable cycles want 0", cap_stall);
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_b[i] !== exp[i]) begin
            fails++; $display("FAIL stall_b%0d got %h want %h", i, cap_b[i], exp[i]);
         end
      end
   endtask

   task automatic test_drop();
      logic [7:0] ea [0:6] = '{8'hA5, 8'h00, 8'h03, 8'h04, 8'h01, 8'h02, 8'h0A};
      logic [7:0] eb [0:6] = '{8'hA5, 8'h81, 8'h22, 8'h22, 8'h11, 8'h11, 8'hE7};
      apply_reset();
      strobe(32'h0102_0304);
      capture(1'b0, 1, 32'hFFFF_FFFF, 1'b0, '0);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_b[i] !== ea[i] || cap_n != 7) begin
            fails++; $display("FAIL drop_a_b%0d got %h want %h", i, cap_b[i], ea[i]);
         end
      end
      checks++;
      if (drop_count !== 16'd1) begin
         fails++; $display("FAIL drop_count got %0d want 1", drop_count);
      end
      strobe(32'h1111_2222);
      capture(1'b0, -1, '0, 1'b0, '0);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_b[i] !== eb[i] || cap_n != 7) begin
            fails++; $display("FAIL drop_b_b%0d got %h want %h", i, cap_b[i], eb[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ec [0:6] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
      logic [7:0] ed [0:6] = '{8'hA5, 8'h03, 8'h00, 8'h10, 8'h00, 8'hFF, 8'h12};
      strobe(32'h0000_0000);
      capture(1'b0, -1, '0, 1'b1, 32'h00FF_0010);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_b[i] !== ec[i] || cap_n != 7) begin
            fails++; $display("FAIL b2b_c_b%0d got %h want %h", i, cap_b[i], ec[i]);
         end
      end
      capture(1'b0, -1, '0, 1'b0, '0);
      checks++;
      if (cap_first != 0) begin
         fails++; $display("FAIL b2b_bubble got first=%0d want 0", cap_first);
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_b[i] !== ed[i] || cap_n != 7) begin
            fails++; $display("FAIL b2b_d_b%0d got %h want %h", i, cap_b[i], ed[i]);
         end
      end
      checks++;
      if (drop_count !== 16'd1) begin
         fails++; $display("FAIL b2b_drop got %0d want 1", drop_count);
      end
   endtask

   task automatic test_seq_wrap();
      logic [31:0] d;
      logic [7:0]  h, cs;
      apply_reset();
      for (int i = 0; i < 130; i++) begin
         d  = 32'(i) * 32'h0103_0507 + 32'h0BAD_F00D;
         h  = {1'b0, 7'(i % 128)};
         cs = h + d[31:24] + d[23:16] + d[15:8] + d[7:0];
         strobe(d);
         capture(1'b0, -1, '0, 1'b0, '0);
         checks++;
         if (cap_to || cap_n != 7 || cap_b[1] !== h) begin
            fails++; $display("FAIL wrap_seq%0d got %h n=%0d want %h", i, cap_b[1], cap_n, h);
         end
         checks++;
         if (cap_b[6] !== cs || cap_b[2] !== d[15:8] || cap_b[5] !== d[23:16]) begin
            fails++; $display("FAIL wrap_csum%0d got %h want %h", i, cap_b[6], cs);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] ee [0:6] = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h03};
      strobe(32'hCAFE_0B0E);
      m_axis_tready = 1'b1;
      @(negedge sys_clk);
      sample_valid = 1'b0;
      @(negedge sys_clk);
      sample_valid = 1'b1;
      @(negedge sys_clk);
      sample_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || m_axis_tdata !== 8'h0B || drop_count !== 16'd1) begin
         fails++;
         $display("FAIL mid_pre got busy=%b tdata=%h drop=%0d want 1 0b 1",
                  busy, m_axis_tdata, drop_count);
      end
      #2 sys_rst_n = 1'b0;
      #1;
      checks++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 8'h00 ||
          busy !== 1'b0 || drop_count !== 16'd0) begin
         fails++;
         $display("FAIL mid_rst got v=%b l=%b d=%h busy=%b drop=%0d want all zero",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, drop_count);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      strobe(32'h0001_0002);
      capture(1'b0, -1, '0, 1'b0, '0);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (cap_b[i] !== ee[i] || cap_n != 7) begin
            fails++; $display("FAIL mid_post_b%0d got %h want %h", i, cap_b[i], ee[i]);
         end
      end
      checks++;
      if (drop_count !== 16'd0) begin
         fails++; $display("FAIL mid_post_drop got %0d want 0", drop_count);
      end
   endtask

   initial begin
      sys_rst_n     = 1'b0;
      sample_valid  = 1'b0;
      sample_data   = '0;
      m_axis_tready = 1'b1;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      test_reset();
      test_basic();
      test_stall();
      test_drop();
      test_back_to_back();
      test_seq_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
